lockin_sequencer: RTL and testbench

Control FSM that sequences the lock-in datapath: it decides when lock-in is enabled and when its state is cleared, and latches the active drift direction fed back to the lock-in block. It also detects loss of lock, retries acquisition on timeout, and reports a sticky fault when retries run out. It sits between the clock-recovery top level and the lock-in datapath. It consumes that datapath's event, violation and lock status outputs, and drives its `lockin_en_i`, `clear_state_i` and `active_drift_direction_i` inputs.

---
 rtl/clks_alot_p.sv | 17 +
 rtl/common_p.sv | 10 +
 rtl/lockin_sequencer_pkg.sv | 9 +
 rtl/lockin_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lockin_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clks_alot_p.sv
// Shared enums for the clock-recovery lock-in path.
package clks_alot_p;

  typedef enum logic {
    PIN_CAME_LATE  = 1'b0,
    PIN_CAME_EARLY = 1'b1
  } drift_direction_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACQUIRE = 3'd2,
    LOCKED  = 3'd3,
    FAULT   = 3'd4
  } lockin_seq_state_e;

endpackage

// File: rtl/common_p.sv
// Clock-domain bundle shared across the clock-recovery blocks.
package common_p;

  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_dom_s;

endpackage

// File: rtl/lockin_sequencer_pkg.sv
// Local helpers for the lock-in sequencer.
package lockin_sequencer_pkg;

  // Width of a counter that must hold 0..limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/lockin_sequencer.sv
// Control FSM for the lock-in datapath: enable/clear sequencing, drift latch,
// loss-of-lock detection, acquisition retries and sticky fault.
module lockin_sequencer
  import lockin_sequencer_pkg::*;
  import clks_alot_p::*;
#(
  parameter int VIOLATION_LIMIT    = 3,
  parameter int ACQ_TIMEOUT_EVENTS = 64,
  parameter int MAX_RETRIES        = 4,
  parameter int CLEAR_CYCLES       = 2,
  localparam int RW                = cnt_width(MAX_RETRIES)
) (
  input  common_p::clk_dom_s             sys_dom_i,
  input  logic                           async_rst_i,
  input  logic                           enable_i,
  input  logic                           restart_i,
  input  logic                           polarity_filtered_event_i,
  input  logic                           rate_violation_i,
  input  logic                           locked_in_i,
  input  logic                           drift_detected_i,
  input  clks_alot_p::drift_direction_e  drift_direction_i,
  output logic                           lockin_en_o,
  output logic                           clear_state_o,
  output clks_alot_p::drift_direction_e  active_drift_direction_o,
  output logic                           active_drift_valid_o,
  output clks_alot_p::lockin_seq_state_e state_o,
  output logic [RW-1:0]                  retry_count_o,
  output logic                           lock_lost_o,
  output logic                           fault_o
);

  localparam int EW = cnt_width(ACQ_TIMEOUT_EVENTS);
  localparam int VW = cnt_width(VIOLATION_LIMIT);
  localparam int CW = cnt_width(CLEAR_CYCLES);

  localparam logic [EW-1:0] EVT_LIMIT   = EW'(ACQ_TIMEOUT_EVENTS);
  localparam logic [VW-1:0] VIOL_LIMIT  = VW'(VIOLATION_LIMIT);
  localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  logic clk;
  logic clk_en;
  logic unused_sync_rst;

  assign clk             = sys_dom_i.clk;
  assign clk_en          = sys_dom_i.clk_en;
  assign unused_sync_rst = sys_dom_i.sync_rst;

  lockin_seq_state_e state_reg, state_next;

  logic [EW-1:0]    evt_cnt_reg;
  logic [VW-1:0]    viol_cnt_reg;
  logic [CW-1:0]    clear_cnt_reg;
  logic [RW-1:0]    retry_reg;
  logic             lost_reg;
  drift_direction_e drift_dir_reg;
  logic             drift_valid_reg;

  logic [EW-1:0] evt_cnt_inc;
  logic [VW-1:0] viol_cnt_inc;
  logic          timeout;
  logic          lock_loss;
  logic          clear_done;
  logic          enter_clear;
  logic          lock_lost_take;

  // Saturating increments and per-state trigger conditions.
  always_comb begin
    evt_cnt_inc  = (evt_cnt_reg == EVT_LIMIT) ? evt_cnt_reg : evt_cnt_reg + EW'(1);
    viol_cnt_inc = (viol_cnt_reg == VIOL_LIMIT) ? viol_cnt_reg : viol_cnt_reg + VW'(1);
    timeout      = (state_reg == ACQUIRE) && polarity_filtered_event_i && (evt_cnt_inc == EVT_LIMIT);
    lock_loss    = (state_reg == LOCKED) && polarity_filtered_event_i && rate_violation_i
                   && (viol_cnt_inc == VIOL_LIMIT);
    clear_done   = (clear_cnt_reg == CLEAR_LAST);
  end

  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_reg <= IDLE;
    end else if (clk_en) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (restart_i) begin
      state_next = CLEAR;
    end else if (!enable_i && (state_reg != FAULT)) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = CLEAR;
        CLEAR:   if (clear_done) state_next = ACQUIRE;
        ACQUIRE: begin
          // A lock reported on the timeout cycle takes precedence over the retry.
          if (locked_in_i) state_next = LOCKED;
          else if (timeout) state_next = (retry_reg == RETRY_LIMIT) ? FAULT : CLEAR;
        end
        LOCKED:  if (lock_loss) state_next = CLEAR;
        FAULT:   state_next = FAULT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    lockin_en_o   = (state_reg == ACQUIRE) || (state_reg == LOCKED);
    clear_state_o = (state_reg == CLEAR);
    fault_o       = (state_reg == FAULT);
  end

  // A restart while already clearing re-arms the clear window too.
  assign enter_clear    = (state_next == CLEAR) && ((state_reg != CLEAR) || restart_i);
  assign lock_lost_take = lock_loss && enable_i && !restart_i;

  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      evt_cnt_reg     <= '0;
      viol_cnt_reg    <= '0;
      clear_cnt_reg   <= '0;
      retry_reg       <= '0;
      lost_reg        <= 1'b0;
      drift_dir_reg   <= PIN_CAME_LATE;
      drift_valid_reg <= 1'b0;
    end else begin
      // Pulse lasts one clk cycle even if the next cycle is not enabled.
      lost_reg <= clk_en && lock_lost_take;
      if (clk_en) begin
        if (enter_clear) begin
          evt_cnt_reg     <= '0;
          viol_cnt_reg    <= '0;
          clear_cnt_reg   <= '0;
          drift_valid_reg <= 1'b0;
        end else begin
          if ((state_reg == CLEAR) && !clear_done) begin
            clear_cnt_reg <= clear_cnt_reg + CW'(1);
          end
          if ((state_reg == ACQUIRE) && polarity_filtered_event_i) begin
            evt_cnt_reg <= evt_cnt_inc;
          end
          if ((state_reg == LOCKED) && polarity_filtered_event_i) begin
            viol_cnt_reg <= rate_violation_i ? viol_cnt_inc : '0;
          end
          if (((state_reg == ACQUIRE) || (state_reg == LOCKED)) && !drift_valid_reg
              && drift_detected_i) begin
            drift_dir_reg   <= drift_direction_i;
            drift_valid_reg <= 1'b1;
          end
        end

        if (restart_i) begin
          retry_reg <= '0;
        end else if ((state_reg == ACQUIRE) && (state_next == LOCKED)) begin
          retry_reg <= '0;
        end else if (timeout && (state_next == CLEAR)) begin
          retry_reg <= retry_reg + RW'(1);
        end
      end
    end
  end

  assign state_o                  = state_reg;
  assign retry_count_o            = retry_reg;
  assign lock_lost_o              = lost_reg;
  assign active_drift_direction_o = drift_dir_reg;
  assign active_drift_valid_o     = drift_valid_reg;

endmodule

// File: tb/tb_lockin_sequencer.sv
// Scoreboard bench for lockin_sequencer: each scenario queues stimulus with its
// expected post-edge outputs, then compares them cycle by cycle.
module tb_lockin_sequencer;
  import common_p::*;
  import clks_alot_p::*;

  localparam int RW = 3;

  typedef struct packed {
    lockin_seq_state_e st;
    logic              en;
    logic              clr;
    logic [RW-1:0]     retry;
    logic              lost;
    logic              fault;
    logic              valid;
    drift_direction_e  dir;
  } snap_t;

  typedef struct packed {
    logic             enable;
    logic             restart;
    logic             evt;
    logic             viol;
    logic             locked;
    logic             drift;
    drift_direction_e dir;
    logic             cke;
  } stim_t;

  typedef struct {
    string name;
    snap_t v;
  } exp_t;

  logic clk = 1'b0;
  logic cke;
  logic rst;
  logic enable, restart, evt, viol, locked, drift;
  drift_direction_e drift_dir;
  clk_dom_s dom;

  logic              lockin_en, clear_state, act_valid, lock_lost, fault;
  drift_direction_e  act_dir;
  lockin_seq_state_e state;
  logic [RW-1:0]     retry_count;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t  exp_q[$];
  stim_t plan_s[$];
  snap_t plan_x[$];
  string plan_n[$];

  assign dom = '{clk: clk, clk_en: cke, sync_rst: 1'b0};

  always #5 clk = ~clk;

  lockin_sequencer dut (
    .sys_dom_i                (dom),
    .async_rst_i              (rst),
    .enable_i                 (enable),
    .restart_i                (restart),
    .polarity_filtered_event_i(evt),
    .rate_violation_i         (viol),
    .locked_in_i              (locked),
    .drift_detected_i         (drift),
    .drift_direction_i        (drift_dir),
    .lockin_en_o              (lockin_en),
    .clear_state_o            (clear_state),
    .active_drift_direction_o (act_dir),
    .active_drift_valid_o     (act_valid),
    .state_o                  (state),
    .retry_count_o            (retry_count),
    .lock_lost_o              (lock_lost),
    .fault_o                  (fault)
  );

  function automatic snap_t mk(lockin_seq_state_e s, int r, logic lost, logic valid,
                               drift_direction_e d);
    snap_t x;
    x.st    = s;
    x.en    = (s == ACQUIRE) || (s == LOCKED);
    x.clr   = (s == CLEAR);
    x.retry = RW'(r);
    x.lost  = lost;
    x.fault = (s == FAULT);
    x.valid = valid;
    x.dir   = d;
    return x;
  endfunction

  function automatic stim_t sv(logic en_v, logic rs_v, logic ev_v, logic vi_v, logic lk_v,
                               logic dr_v, drift_direction_e d, logic ck_v);
    stim_t s;
    s.enable  = en_v;
    s.restart = rs_v;
    s.evt     = ev_v;
    s.viol    = vi_v;
    s.locked  = lk_v;
    s.drift   = dr_v;
    s.dir     = d;
    s.cke     = ck_v;
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t x;
    x.st    = state;
    x.en    = lockin_en;
    x.clr   = clear_state;
    x.retry = retry_count;
    x.lost  = lock_lost;
    x.fault = fault;
    x.valid = act_valid;
    x.dir   = act_dir;
    return x;
  endfunction

  task automatic apply(input stim_t s);
    enable    = s.enable;
    restart   = s.restart;
    evt       = s.evt;
    viol      = s.viol;
    locked    = s.locked;
    drift     = s.drift;
    drift_dir = s.dir;
    cke       = s.cke;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input stim_t s, input snap_t x);
    plan_n.push_back(n);
    plan_s.push_back(s);
    plan_x.push_back(x);
  endtask

  task automatic test_reset();
    exp_t  e;
    snap_t obs;
    rst = 1'b1;
    apply(sv(0, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1));
    exp_q.push_back('{name: "reset", v: mk(IDLE, 0, 0, 0, PIN_CAME_LATE)});
    #3;
    e   = exp_q.pop_front();
    obs = observe();
    n_cmp++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", e.name, obs, e.v);
    end
    $display("[%0t] %s state=%0d retry=%0d", $time, e.name, obs.st, obs.retry);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_acquire_lock();
    exp_t  e;
    snap_t obs;
    add("acq_clear0", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_LATE));
    add("acq_clear1", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_LATE));
    add("acq_enter", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(ACQUIRE, 0, 0, 0, PIN_CAME_LATE));
    for (int i = 1; i <= 5; i++)
      add($sformatf("acq_evt%0d", i), sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1),
          mk(ACQUIRE, 0, 0, 0, PIN_CAME_LATE));
    add("acq_lock", sv(1, 0, 0, 0, 1, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_LATE));
    foreach (plan_s[i]) begin
      apply(plan_s[i]);
      exp_q.push_back('{name: plan_n[i], v: plan_x[i]});
      tick();
      e   = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", e.name, obs, e.v);
      end
      $display("[%0t] %s state=%0d retry=%0d", $time, e.name, obs.st, obs.retry);
    end
    plan_s.delete(); plan_x.delete(); plan_n.delete();
  endtask

  task automatic test_lock_loss();
    exp_t  e;
    snap_t obs;
    add("loss_unlock_ignored", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_LATE));
    add("loss_v1", sv(1, 0, 1, 1, 0, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_LATE));
    add("loss_v2", sv(1, 0, 1, 1, 0, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_LATE));
    add("loss_clean", sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_LATE));
    add("loss_v1b", sv(1, 0, 1, 1, 0, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_LATE));
    add("loss_v2b", sv(1, 0, 1, 1, 0, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_LATE));
    add("loss_v3b", sv(1, 0, 1, 1, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 1, 0, PIN_CAME_LATE));
    add("loss_clear1", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_LATE));
    add("loss_reacq", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(ACQUIRE, 0, 0, 0, PIN_CAME_LATE));
    foreach (plan_s[i]) begin
      apply(plan_s[i]);
      exp_q.push_back('{name: plan_n[i], v: plan_x[i]});
      tick();
      e   = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", e.name, obs, e.v);
      end
      $display("[%0t] %s state=%0d lost=%0d", $time, e.name, obs.st, obs.lost);
    end
    plan_s.delete(); plan_x.delete(); plan_n.delete();
  endtask

  task automatic test_drift();
    exp_t  e;
    snap_t obs;
    add("drift_early", sv(1, 0, 0, 0, 0, 1, PIN_CAME_EARLY, 1), mk(ACQUIRE, 0, 0, 1, PIN_CAME_EARLY));
    add("drift_late_ign", sv(1, 0, 0, 0, 0, 1, PIN_CAME_LATE, 1), mk(ACQUIRE, 0, 0, 1, PIN_CAME_EARLY));
    add("drift_restart", sv(1, 1, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_EARLY));
    add("drift_clear1", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_EARLY));
    add("drift_reacq", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(ACQUIRE, 0, 0, 0, PIN_CAME_EARLY));
    foreach (plan_s[i]) begin
      apply(plan_s[i]);
      exp_q.push_back('{name: plan_n[i], v: plan_x[i]});
      tick();
      e   = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", e.name, obs, e.v);
      end
      $display("[%0t] %s valid=%0d dir=%0d", $time, e.name, obs.valid, obs.dir);
    end
    plan_s.delete(); plan_x.delete(); plan_n.delete();
  endtask

  task automatic test_timeout_fault();
    exp_t  e;
    snap_t obs;
    for (int r = 0; r <= 4; r++) begin
      for (int ev = 1; ev <= 64; ev++) begin
        if (ev < 64)
          add($sformatf("to_r%0d_e%0d", r, ev), sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1),
              mk(ACQUIRE, r, 0, 0, PIN_CAME_EARLY));
        else if (r < 4)
          add($sformatf("to_r%0d_retry", r), sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1),
              mk(CLEAR, r + 1, 0, 0, PIN_CAME_EARLY));
        else
          add("to_fault", sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1), mk(FAULT, 4, 0, 0, PIN_CAME_EARLY));
      end
      if (r < 4) begin
        add($sformatf("to_r%0d_clr", r), sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1),
            mk(CLEAR, r + 1, 0, 0, PIN_CAME_EARLY));
        add($sformatf("to_r%0d_acq", r), sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1),
            mk(ACQUIRE, r + 1, 0, 0, PIN_CAME_EARLY));
      end
    end
    add("fault_hold0", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(FAULT, 4, 0, 0, PIN_CAME_EARLY));
    add("fault_hold1", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(FAULT, 4, 0, 0, PIN_CAME_EARLY));
    add("fault_no_idle", sv(0, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(FAULT, 4, 0, 0, PIN_CAME_EARLY));
    add("restart_dis", sv(0, 1, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_EARLY));
    add("disable_idle", sv(0, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(IDLE, 0, 0, 0, PIN_CAME_EARLY));
    foreach (plan_s[i]) begin
      apply(plan_s[i]);
      exp_q.push_back('{name: plan_n[i], v: plan_x[i]});
      tick();
      e   = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", e.name, obs, e.v);
      end
      $display("[%0t] %s state=%0d retry=%0d", $time, e.name, obs.st, obs.retry);
    end
    plan_s.delete(); plan_x.delete(); plan_n.delete();
  endtask

  task automatic test_lock_coincide();
    exp_t  e;
    snap_t obs;
    add("co_clear0", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_EARLY));
    add("co_clear1", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_EARLY));
    add("co_acq", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(ACQUIRE, 0, 0, 0, PIN_CAME_EARLY));
    for (int ev = 1; ev <= 64; ev++)
      add($sformatf("co_pre_e%0d", ev), sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1),
          (ev < 64) ? mk(ACQUIRE, 0, 0, 0, PIN_CAME_EARLY) : mk(CLEAR, 1, 0, 0, PIN_CAME_EARLY));
    add("co_clr", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(CLEAR, 1, 0, 0, PIN_CAME_EARLY));
    add("co_acq2", sv(1, 0, 0, 0, 0, 0, PIN_CAME_LATE, 1), mk(ACQUIRE, 1, 0, 0, PIN_CAME_EARLY));
    for (int ev = 1; ev <= 63; ev++)
      add($sformatf("co_e%0d", ev), sv(1, 0, 1, 0, 0, 0, PIN_CAME_LATE, 1),
          mk(ACQUIRE, 1, 0, 0, PIN_CAME_EARLY));
    add("co_e64_lock", sv(1, 0, 1, 0, 1, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_EARLY));
    foreach (plan_s[i]) begin
      apply(plan_s[i]);
      exp_q.push_back('{name: plan_n[i], v: plan_x[i]});
      tick();
      e   = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", e.name, obs, e.v);
      end
      $display("[%0t] %s state=%0d retry=%0d", $time, e.name, obs.st, obs.retry);
    end
    plan_s.delete(); plan_x.delete(); plan_n.delete();
  endtask

  task automatic test_clk_en();
    exp_t  e;
    snap_t obs;
    for (int i = 0; i < 10; i++)
      add($sformatf("cke_off%0d", i), sv(0, 0, 1, 1, 1, 1, PIN_CAME_LATE, 0),
          mk(LOCKED, 0, 0, 0, PIN_CAME_EARLY));
    add("cke_v1", sv(1, 0, 1, 1, 1, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_EARLY));
    add("cke_v2", sv(1, 0, 1, 1, 1, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_EARLY));
    add("cke_v3", sv(1, 0, 1, 1, 1, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 1, 0, PIN_CAME_EARLY));
    add("cke_clr1", sv(1, 0, 0, 0, 1, 0, PIN_CAME_LATE, 1), mk(CLEAR, 0, 0, 0, PIN_CAME_EARLY));
    add("cke_acq", sv(1, 0, 0, 0, 1, 0, PIN_CAME_LATE, 1), mk(ACQUIRE, 0, 0, 0, PIN_CAME_EARLY));
    add("cke_lock", sv(1, 0, 0, 0, 1, 0, PIN_CAME_LATE, 1), mk(LOCKED, 0, 0, 0, PIN_CAME_EARLY));
    foreach (plan_s[i]) begin
      apply(plan_s[i]);
      exp_q.push_back('{name: plan_n[i], v: plan_x[i]});
      tick();
      e   = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", e.name, obs, e.v);
      end
      $display("[%0t] %s state=%0d lost=%0d", $time, e.name, obs.st, obs.lost);
    end
    plan_s.delete(); plan_x.delete(); plan_n.delete();
  endtask

  task automatic test_async_reset();
    exp_t  e;
    snap_t obs;
    apply(sv(1, 0, 0, 0, 1, 1, PIN_CAME_EARLY, 1));
    exp_q.push_back('{name: "ar_latch", v: mk(LOCKED, 0, 0, 1, PIN_CAME_EARLY)});
    tick();
    e   = exp_q.pop_front();
    obs = observe();
    n_cmp++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", e.name, obs, e.v);
    end
    $display("[%0t] %s state=%0d valid=%0d", $time, e.name, obs.st, obs.valid);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        #3;
        rst = 1'b1;
        #1;
      end else begin
        tick();
      end
      exp_q.push_back('{name: (k == 0) ? "ar_between_edges" : "ar_held",
                        v: mk(IDLE, 0, 0, 0, PIN_CAME_LATE)});
      e   = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", e.name, obs, e.v);
      end
      $display("[%0t] %s state=%0d dir=%0d", $time, e.name, obs.st, obs.dir);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_acquire_lock();
    test_lock_loss();
    test_drift();
    test_timeout_fault();
    test_lock_coincide();
    test_clk_en();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
